// File: rtl/seq_signed_divider.sv
// Multicycle signed restoring divider for the DIV/DIVM path.
// Produces quotient on lo_out and remainder on hi_out; flags divide-by-zero.
module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] rs_in,
    input  logic [WIDTH-1:0] rt_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        ZERO
    } state_t;

    state_t state;

    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // |0x80000000| wraps back to itself, which is the right unsigned magnitude.
    always_comb begin
        rs_mag  = rs_in[WIDTH-1] ? -rs_in : rs_in;
        rt_mag  = rt_in[WIDTH-1] ? -rt_in : rt_in;
        shifted = {rem, dvd[WIDTH-1]};
        ge      = shifted >= {1'b0, dvs};
        diff    = shifted[WIDTH-1:0] - dvs;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            count    <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign_q   <= rs_in[WIDTH-1] ^ rt_in[WIDTH-1];
                        sign_r   <= rs_in[WIDTH-1];
                        dvd      <= rs_mag;
                        dvs      <= rt_mag;
                        rem      <= '0;
                        count    <= '0;
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (rt_in == '0) ? ZERO : CALC;
                    end
                end
                CALC: begin
                    // Quotient bits shift into the vacated dividend LSBs.
                    rem   <= ge ? diff : shifted[WIDTH-1:0];
                    dvd   <= {dvd[WIDTH-2:0], ge};
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo_out <= sign_q ? -dvd : dvd;
                    hi_out <= sign_r ? -rem : rem;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                ZERO: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
